// File: rtl/activation_pkg.sv
// activation_pkg
//   Shared Q4.12 activation types and the piecewise-linear tanh breakpoints.
//   The forward tanh unit and the inverse (atanh) units both use these, so the
//   two stay exact inverses of each other.
//   Contents:
//     q4_12_t  signed 16-bit Q4.12 value
//     seg_e    linear segment of the tanh curve (or SAT when not invertible)
//     Q_*      breakpoint / offset constants in Q4.12
//     seg_of() magnitude -> segment classification
package activation_pkg;

    typedef logic signed [15:0] q4_12_t;

    typedef enum logic [1:0] {
        SEG0,
        SEG1,
        SEG2,
        SAT
    } seg_e;

    localparam logic [15:0] Q_0P25 = 16'h0400;
    localparam logic [15:0] Q_0P5  = 16'h0800;
    localparam logic [15:0] Q_0P7  = 16'h0B33;
    localparam logic [15:0] Q_0P85 = 16'h0D99;
    localparam logic [15:0] Q_1P0  = 16'h1000;

    // Segment of an activation magnitude. Anything at or above 1.0 lies
    // outside the range of the forward function and cannot be inverted.
    function automatic seg_e seg_of(input logic [15:0] a);
        if (a < Q_0P5)
            return SEG0;
        else if (a < Q_0P85)
            return SEG1;
        else if (a < Q_1P0)
            return SEG2;
        else
            return SAT;
    endfunction

endpackage

// File: rtl/atanh_pwl_core.sv
// atanh_pwl_core
//   Combinational magnitude mapping of the inverse piecewise-linear tanh.
//   Takes an activation magnitude and its segment, returns the pre-activation
//   magnitude. Kept separate so a non-streamed inverse can reuse it.
//   Parameters:
//     SAT_VAL  magnitude returned for the SAT segment
//   Ports:
//     a    in   16  activation magnitude |y| (unsigned Q4.12)
//     seg  in   2   segment of a
//     m    out  16  pre-activation magnitude |x| (unsigned Q4.12)
module atanh_pwl_core
    import activation_pkg::*;
#(
    parameter logic [15:0] SAT_VAL = 16'h7FFF
) (
    input  logic [15:0] a,
    input  seg_e        seg,
    output logic [15:0] m
);

    logic [16:0] m_wide;

    // Clamp a 17-bit intermediate into 16 bits. Valid segment inputs never
    // exceed 0x2660, so this only matters if a and seg disagree.
    function automatic logic [15:0] clamp16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

    // Each segment undoes the forward slope: SEG0 has slope 1, SEG1 slope 1/2
    // about 0.25, SEG2 slope 1/8 about 0.7.
    always_comb begin
        m_wide = 17'd0;
        case (seg)
            SEG0:    m_wide = {1'b0, a};
            SEG1:    m_wide = ({1'b0, a} - {1'b0, Q_0P25}) << 1;
            SEG2:    m_wide = ({1'b0, a} - {1'b0, Q_0P7}) << 3;
            default: m_wide = {1'b0, SAT_VAL};
        endcase
        m = clamp16(m_wide);
    end

endmodule

// File: rtl/atanh_pwl_stream.sv
// atanh_pwl_stream
//   Streaming inverse of the piecewise-linear tanh activation. Maps a Q4.12
//   activation y back to its Q4.12 pre-activation x through a two-stage
//   valid/ready pipeline (stage 1: sign/magnitude/segment, stage 2: mapped
//   value with sign restored).
//   Parameters:
//     PIPE_BYPASS  1 makes stage 2 combinational (latency 1 instead of 2)
//     SAT_VAL      output magnitude when |y| >= 1.0
//   Optional feature (macro ATANH_SAT_CNT_EN):
//     adds the sat_count port, a saturating count of saturated output beats.
//   Ports:
//     clk        in   1   clock
//     rst_n      in   1   asynchronous active-low reset
//     in_valid   in   1   input beat valid
//     in_ready   out  1   input beat can be accepted
//     in_data    in   16  signed Q4.12 activation y
//     out_valid  out  1   output beat valid
//     out_ready  in   1   downstream accepts output beat
//     out_data   out  16  signed Q4.12 pre-activation x
//     out_sat    out  1   this beat was saturated
//     sat_count  out  16  saturated-beat count (ATANH_SAT_CNT_EN only)
module atanh_pwl_stream
    import activation_pkg::*;
#(
    parameter int          PIPE_BYPASS = 0,
    parameter logic [15:0] SAT_VAL     = 16'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  q4_12_t      in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output q4_12_t      out_data,
    output logic        out_sat
`ifdef ATANH_SAT_CNT_EN
    ,
    output logic [15:0] sat_count
`endif
);

    // Magnitude of a Q4.12 value; -1.0*8 (0x8000) stays 0x8000 and so falls
    // into the SAT segment.
    function automatic logic [15:0] mag16(input q4_12_t v);
        logic [15:0] u;
        u = v;
        return v[15] ? (~u + 16'd1) : u;
    endfunction

    // Reapply the sign; a zero magnitude gives zero either way.
    function automatic q4_12_t apply_sign(input logic sign, input logic [15:0] m);
        return sign ? q4_12_t'(~m + 16'd1) : q4_12_t'(m);
    endfunction

    logic [15:0] a_c;
    seg_e        seg_c;

    logic        vld_p1;
    logic        sign_p1;
    logic        sat_p1;
    logic [15:0] a_p1;
    seg_e        seg_p1;
    logic [15:0] m_p1;

    logic        adv_p1;
    logic        adv_p2;

    assign a_c   = mag16(in_data);
    assign seg_c = seg_of(a_c);

    // Stage 2 (or the output, when bypassed) can take a beat whenever the
    // output slot is empty or being drained this cycle.
    assign adv_p2   = !out_valid || out_ready;
    assign adv_p1   = !vld_p1 || adv_p2;
    assign in_ready = adv_p1;

    // ---- stage 1: sign, magnitude, segment ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            sign_p1 <= 1'b0;
            sat_p1  <= 1'b0;
            a_p1    <= 16'd0;
            seg_p1  <= SEG0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sign_p1 <= in_data[15];
                sat_p1  <= (seg_c == SAT);
                a_p1    <= a_c;
                seg_p1  <= seg_c;
            end
        end
    end

    atanh_pwl_core #(
        .SAT_VAL (SAT_VAL)
    ) u_core (
        .a   (a_p1),
        .seg (seg_p1),
        .m   (m_p1)
    );

    // ---- stage 2: mapped value with sign restored ----
    generate
        if (PIPE_BYPASS != 0) begin : g_bypass
            assign out_valid = vld_p1;
            assign out_data  = apply_sign(sign_p1, m_p1);
            assign out_sat   = sat_p1;
        end else begin : g_reg
            logic   vld_p2;
            q4_12_t data_p2;
            logic   sat_p2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p2  <= 1'b0;
                    data_p2 <= '0;
                    sat_p2  <= 1'b0;
                end else if (adv_p2) begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        data_p2 <= apply_sign(sign_p1, m_p1);
                        sat_p2  <= sat_p1;
                    end
                end
            end

            assign out_valid = vld_p2;
            assign out_data  = data_p2;
            assign out_sat   = sat_p2;
        end
    endgenerate

`ifdef ATANH_SAT_CNT_EN
    // ---- saturated-beat counter, sticks at all-ones ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= 16'd0;
        end else if (out_valid && out_ready && out_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_atanh_pwl_stream.sv
module tb_atanh_pwl_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_sat;
`ifdef ATANH_SAT_CNT_EN
    logic [15:0] sat_count;
`endif

    always #5 clk = ~clk;

    atanh_pwl_stream dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
`ifdef ATANH_SAT_CNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          pushed = 0;
    int          exp_sat_cnt = 0;
    bit          chk_lat = 0;
    bit          hold = 0;
    logic [15:0] hold_d = 16'h0;
    logic        hold_s = 1'b0;

    logic [15:0] dir_in  [12] = '{16'h0000, 16'h0400, 16'h0800, 16'h0B33, 16'hF800, 16'h0D98,
                                  16'h0D99, 16'h0FFF, 16'hF001, 16'h1000, 16'h7FFF, 16'h8000};
    logic [15:0] dir_exp [12] = '{16'h0000, 16'h0400, 16'h0800, 16'h0E66, 16'hF800, 16'h1330,
                                  16'h1330, 16'h2660, 16'hD9A0, 16'h7FFF, 16'h7FFF, 16'h8001};
    logic        dir_sat [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Inverse tanh PWL from the segment definitions, in plain integers.
    function automatic void ref_model(input logic [15:0] y, output logic [15:0] x, output logic s);
        int v, a, m;
        v = int'($signed(y));
        a = (v < 0) ? -v : v;
        if (a < 'h800)       m = a;
        else if (a < 'hD99)  m = 2 * (a - 'h400);
        else if (a < 'h1000) m = 8 * (a - 'hB33);
        else                 m = 'h7FFF;
        s = (a >= 'h1000);
        x = 16'((v < 0) ? -m : m);
    endfunction

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        case ($urandom_range(0, 3))
            0: v = 16'($urandom);
            1, 2: v = 16'($urandom_range(0, 'h1FFF)) - 16'h1000;
            default: begin
                case ($urandom_range(0, 5))
                    0: v = 16'h8000;
                    1: v = 16'h07FF;
                    2: v = 16'h0D98;
                    3: v = 16'hF267;
                    4: v = 16'h1000;
                    default: v = 16'hF000;
                endcase
            end
        endcase
        return v;
    endfunction

    // One clock cycle: check outputs, drive inputs, score any handshakes.
    task automatic step(input logic iv, input logic [15:0] d, input logic ordy,
                        input bit use_exp, input logic [15:0] ed, input logic es);
        exp_t        e;
        logic [15:0] md;
        logic        ms;
        @(negedge clk);
        cyc++;
        if (hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, hold_d);
            chk("hold_sat", out_sat, hold_s);
        end
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk("in_ready", in_ready, !(q.size() == 2 && !ordy));
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                e = q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_sat", out_sat, e.s);
                if (e.s) exp_sat_cnt++;
                if (chk_lat) chk("latency", cyc - e.cyc, 2);
            end
        end
        if (in_valid && in_ready) begin
            if (use_exp) begin
                md = ed;
                ms = es;
            end else begin
                ref_model(d, md, ms);
            end
            e.d = md;
            e.s = ms;
            e.cyc = cyc;
            q.push_back(e);
            pushed++;
        end
        hold   = out_valid && !out_ready;
        hold_d = out_data;
        hold_s = out_sat;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            step(0, 16'h0, 1, 0, 16'h0, 0);
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        int n;
        logic iv;

        // Reset and the first cycle after release.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef ATANH_SAT_CNT_EN
        chk("rst_sat_count", sat_count, 0);
`endif

        // Directed vectors back to back, each two cycles after acceptance.
        chk_lat = 1;
        for (int i = 0; i < 12; i++) begin
            step(1, dir_in[i], 1, 1, dir_exp[i], dir_sat[i]);
        end
        drain();
        chk_lat = 0;
`ifdef ATANH_SAT_CNT_EN
        chk("sat_count_dir", sat_count, 3);
`endif

        // Eight beats with random backpressure.
        start = pushed;
        n = 0;
        while ((pushed - start < 8 || q.size() != 0) && n < 400) begin
            iv = (pushed - start < 8) && ($urandom_range(0, 3) != 0);
            step(iv, rand_val(), 1'($urandom_range(0, 1)), 0, 16'h0, 0);
            n++;
        end
        chk("stream8_count", pushed - start, 8);
        chk("stream8_empty", q.size(), 0);

        // Longer random run.
        start = pushed;
        n = 0;
        while ((pushed - start < 300 || q.size() != 0) && n < 3000) begin
            iv = (pushed - start < 300) && ($urandom_range(0, 4) != 0);
            step(iv, rand_val(), 1'($urandom_range(0, 3) != 0), 0, 16'h0, 0);
            n++;
        end
        chk("stream300_count", pushed - start, 300);
        chk("stream300_empty", q.size(), 0);
`ifdef ATANH_SAT_CNT_EN
        chk("sat_count_rand", sat_count, exp_sat_cnt);
`endif

        // Reset with two beats in flight.
        step(1, 16'h0100, 0, 0, 16'h0, 0);
        step(1, 16'h0200, 0, 0, 16'h0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("inflight_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", out_data, 16'h0);
        q.delete();
        hold = 0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 16'h0, 1, 0, 16'h0, 0);
            chk("no_stale", out_valid, 0);
        end
`ifdef ATANH_SAT_CNT_EN
        chk("sat_count_rst", sat_count, 0);
`endif

        // Pipe still works after the mid-stream reset.
        chk_lat = 1;
        step(1, 16'hF001, 1, 0, 16'h0, 0);
        step(1, 16'h0B33, 1, 0, 16'h0, 0);
        drain();
        chk_lat = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/atanh_pwl_stream.md
Name: atanh_pwl_stream

Overview:
- Streaming inverse of the accelerator's piecewise-linear tanh activation.
- Maps a Q4.12 activation value back to its pre-activation Q4.12 value, using the exact inverse of the three linear tanh segments.
- Used for RNN gradient and state-reconstruction paths.
- Two-stage valid/ready pipeline; sits between activation buffers and the backprop MAC array.

Parameters:
- PIPE_BYPASS, 0, 1 = the stage-2 register becomes combinational, giving a latency of 1.
- SAT_VAL, 16'h7FFF, magnitude output when |in| is outside the invertible range.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept an input beat
- in_data  in  16  signed Q4.12 activation value y
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat
- out_data  out  16  signed Q4.12 pre-activation value x
- out_sat  out  1  this beat was saturated
- sat_count  out  16  saturated-beat count (present only with ATANH_SAT_CNT_EN)

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, out_data=0, out_sat=0, sat_count=0, all internal valids 0. in_ready is 1 in the first cycle after reset release.
- Handshake: a transfer occurs when valid && ready are both high at a clk edge.
- Stability: out_data and out_sat hold stable while out_valid && !out_ready.
- No ready-on-valid dependency: in_valid does not combinationally affect in_ready.
- Stage 1 registers: sign = in_data[15]; a = |in_data|; seg (2-bit); sat.
  - in_data = 16'h8000 gives sat=1.
  - Segment select uses constants in Q4.12:
  - a < 0x0800 → SEG0
  - a < 0x0D99 → SEG1
  - a < 0x1000 → SEG2
  - otherwise → SAT
- Stage 2 registers the magnitude m:
  - SEG0: m = a
  - SEG1: m = (a − 0x0400) << 1
  - SEG2: m = (a − 0x0B33) << 3
  - SAT: m = SAT_VAL
- Width: intermediate results are 17-bit unsigned. The maximum SEG2 result is 0x2660, so no overflow occurs.
- Output sign: out_data = sign ? −m : m.
- Zero: input 0x0000 gives output 0x0000 with no sign artefact.
- Stalling: stage 2 advances when !out_valid || out_ready. Stage 1 advances when !s1_valid || stage 2 advances. in_ready = stage-1 advance condition.
- Latency: 2 cycles from input transfer to out_valid (1 cycle with PIPE_BYPASS). Throughput is 1 beat per cycle while out_ready=1.
- Simultaneous events: when out_ready and in_valid are both high with a full pipe, the pipe shifts and accepts in the same cycle. No bubble and no beat loss.
- Reset mid-operation: all in-flight beats are discarded and valids clear immediately (asynchronously).
- Ordering: strictly in order; no beat is dropped or duplicated.

Optional Feature:
- Macro: ATANH_SAT_CNT_EN.
- Defined:
  - sat_count increments on each output transfer with out_sat=1.
  - sat_count saturates at 0xFFFF and does not wrap.
  - sat_count is cleared only by reset.
- Undefined:
  - The sat_count port and counter are absent.
  - out_sat is still present.

Decomposition:
- Package activation_pkg contains:
  - typedef q4_12_t (logic signed [15:0])
  - enum seg_e {SEG0, SEG1, SEG2, SAT}
  - Breakpoint constants Q_0P5=0x0800, Q_0P25=0x0400, Q_0P7=0x0B33, Q_0P85=0x0D99, Q_1P0=0x1000
  - These constants are shared with the forward tanh unit.
- Sub-module atanh_pwl_core is the combinational magnitude mapping (a, seg → m). It is reused by any future non-streamed inverse.

Test Plan:
- Reset with rst_n=0, then release → out_valid=0, out_data=0, in_ready=1. Then inputs 0x0000 and 0x0400 with out_ready=1 → outputs 0x0000 and 0x0400, each 2 cycles after acceptance, out_sat=0.
- Input 0x0800 → 0x0800; input 0x0B33 → 0x0E66; input 0xF800 (−0.5) → 0xF800; input 0x0D98 → 0x1330.
- Input 0x0D99 → 0x1330; input 0x0FFF → 0x2660; input 0xF001 → 0xD9A0.
- Inputs 0x1000, 0x7FFF, 0x8000 → outputs 0x7FFF, 0x7FFF, 0x8001, each with out_sat=1. With ATANH_SAT_CNT_EN, sat_count=3.
- Stream 8 beats with out_ready toggled pseudo-randomly:
  - All 8 outputs arrive in order, none dropped.
  - out_data stays stable during stalls.
  - in_ready falls only once both stages are full.
- Assert rst_n=0 with 2 beats in flight → out_valid drops asynchronously. After release, no stale beat appears.
